// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pipe_ctrl_pkg : shared types for the pipeline hazard controller    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package pipe_ctrl_pkg;

    // Entries store rd at this fixed width; REG_ADDRESS_LENGTH must not exceed it.
    localparam int ENTRY_RD_W      = 8;
    localparam int FWD_SEL_REGFILE = 0;

    typedef struct packed {
        logic                  valid;
        logic                  we;
        logic [ENTRY_RD_W-1:0] rd;
        logic                  is_load;
        logic                  is_mem;
    } entry_t;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } ctrl_state_t;

endpackage
`default_nettype wire

// File: rtl/fwd_prio_sel.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fwd_prio_sel : youngest-match forward select over scoreboard       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module fwd_prio_sel
    import pipe_ctrl_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int FWD_W      = $clog2(DEPTH + 1),
    parameter int R0_IS_ZERO = 0
) (
    input  entry_t [DEPTH-1:0]      i_entries,
    input  logic [ENTRY_RD_W-1:0]   i_rs,
    input  logic                    i_use,
    output logic [FWD_W-1:0]        o_sel,
    output logic                    o_match0
);

    logic [DEPTH-1:0] w_match;
    logic             w_rs_masked;
    logic             w_unused_flags;

    assign w_rs_masked = (R0_IS_ZERO != 0) && (i_rs == '0);

    for (genvar k = 0; k < DEPTH; k++) begin : g_match
        assign w_match[k] = i_entries[k].valid & i_entries[k].we & i_use &
                            (i_entries[k].rd == i_rs) & ~w_rs_masked;
    end

    // Scan oldest to youngest so the youngest match overwrites.
    always_comb begin
        o_sel = FWD_W'(FWD_SEL_REGFILE);
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (w_match[k]) begin
                o_sel = FWD_W'(k + 1);
            end
        end
    end

    assign o_match0 = w_match[0];

    always_comb begin
        w_unused_flags = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            w_unused_flags = w_unused_flags ^ i_entries[k].is_load ^ i_entries[k].is_mem;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pipe_hazard_ctrl : scoreboard hazard/forward/stall controller.     |
// | Define PIPE_HAZARD_PERF_EN to add saturating perf counters.        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDRESS_LENGTH = 5,
    parameter int DEPTH              = 2,
    parameter int LOAD_LATENCY       = 0,
    parameter int R0_IS_ZERO         = 0,
    parameter int FWD_W              = $clog2(DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          id_valid,
    input  logic [REG_ADDRESS_LENGTH-1:0] id_rs_a,
    input  logic [REG_ADDRESS_LENGTH-1:0] id_rs_b,
    input  logic                          id_use_a,
    input  logic                          id_use_b,
    input  logic [REG_ADDRESS_LENGTH-1:0] id_rd,
    input  logic                          id_we,
    input  logic                          id_is_load,
    input  logic                          id_is_mem,
    input  logic                          branch_taken,
    input  logic                          dmem_ack,
    output logic                          pc_stall,
    output logic                          ifid_stall,
    output logic                          ifid_flush,
    output logic                          idex_bubble,
    output logic                          dmem_req,
    output logic [FWD_W-1:0]              fwd_sel_a,
    output logic [FWD_W-1:0]              fwd_sel_b,
    output logic [DEPTH-1:0]              stage_valid,
`ifdef PIPE_HAZARD_PERF_EN
    output logic [31:0]                   perf_stall_cnt,
    output logic [31:0]                   perf_flush_cnt,
    output logic [31:0]                   perf_lu_cnt,
`endif
    output logic                          wb_valid,
    output logic                          wb_we,
    output logic [REG_ADDRESS_LENGTH-1:0] wb_rd
);

    entry_t [DEPTH-1:0]     r_entry;
    ctrl_state_t            r_state;
    ctrl_state_t            w_state_nxt;
    entry_t                 w_id_entry;
    logic [ENTRY_RD_W-1:0]  w_rs_a;
    logic [ENTRY_RD_W-1:0]  w_rs_b;
    logic                   w_m0_a;
    logic                   w_m0_b;
    logic                   w_freeze;
    logic                   w_lu;

    assign w_rs_a = ENTRY_RD_W'(id_rs_a);
    assign w_rs_b = ENTRY_RD_W'(id_rs_b);

    assign w_id_entry = '{valid:   id_valid,
                          we:      id_we,
                          rd:      ENTRY_RD_W'(id_rd),
                          is_load: id_is_load,
                          is_mem:  id_is_mem};

    fwd_prio_sel #(
        .DEPTH      (DEPTH),
        .FWD_W      (FWD_W),
        .R0_IS_ZERO (R0_IS_ZERO)
    ) u_fwd_a (
        .i_entries (r_entry),
        .i_rs      (w_rs_a),
        .i_use     (id_use_a),
        .o_sel     (fwd_sel_a),
        .o_match0  (w_m0_a)
    );

    fwd_prio_sel #(
        .DEPTH      (DEPTH),
        .FWD_W      (FWD_W),
        .R0_IS_ZERO (R0_IS_ZERO)
    ) u_fwd_b (
        .i_entries (r_entry),
        .i_rs      (w_rs_b),
        .i_use     (id_use_b),
        .o_sel     (fwd_sel_b),
        .o_match0  (w_m0_b)
    );

    assign dmem_req = r_entry[0].valid & r_entry[0].is_mem;
    assign w_freeze = dmem_req & ~dmem_ack;
    assign w_lu     = (LOAD_LATENCY != 0) && id_valid && r_entry[0].is_load && (w_m0_a || w_m0_b);

    // A pending dmem access outranks load-use; flush only when ID actually advances.
    always_comb begin
        w_state_nxt = r_state;
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        case (r_state)
            RUN:      if (w_freeze) w_state_nxt = MEM_WAIT;
            MEM_WAIT: if (dmem_ack) w_state_nxt = RUN;
            default:  w_state_nxt = RUN;
        endcase
        if (w_freeze) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
        end else if (w_lu) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_bubble = 1'b1;
        end else begin
            ifid_flush = branch_taken & id_valid;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= RUN;
            r_entry <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (!w_freeze) begin
                for (int k = DEPTH - 1; k > 0; k--) begin
                    r_entry[k] <= r_entry[k-1];
                end
                r_entry[0] <= w_lu ? entry_t'('0) : w_id_entry;
            end
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage_valid
        assign stage_valid[k] = r_entry[k].valid;
    end

    assign wb_valid = r_entry[DEPTH-1].valid;
    assign wb_we    = r_entry[DEPTH-1].valid & r_entry[DEPTH-1].we;
    assign wb_rd    = r_entry[DEPTH-1].rd[REG_ADDRESS_LENGTH-1:0];

`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_flush;
    logic [31:0] r_perf_lu;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perf_stall <= '0;
            r_perf_flush <= '0;
            r_perf_lu    <= '0;
        end else begin
            if (w_freeze && (r_perf_stall != 32'hFFFF_FFFF)) r_perf_stall <= r_perf_stall + 32'd1;
            if (ifid_flush && (r_perf_flush != 32'hFFFF_FFFF)) r_perf_flush <= r_perf_flush + 32'd1;
            if (w_lu && (r_perf_lu != 32'hFFFF_FFFF)) r_perf_lu <= r_perf_lu + 32'd1;
        end
    end

    assign perf_stall_cnt = r_perf_stall;
    assign perf_flush_cnt = r_perf_flush;
    assign perf_lu_cnt    = r_perf_lu;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// Bench for pipe_hazard_ctrl: two configurations driven in lockstep and
// compared against an in-flight instruction history model.
`timescale 1ns/1ps
module tb_pipe_hazard_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       id_valid, use_a, use_b, we, ld, mem, br, ack;
    logic [4:0] rs_a, rs_b, rd;

    logic       d0_pc, d0_ifs, d0_fl, d0_bub, d0_req, d0_wbv, d0_wbwe;
    logic [1:0] d0_fa, d0_fb, d0_sv;
    logic [4:0] d0_wbrd;
    logic       d1_pc, d1_ifs, d1_fl, d1_bub, d1_req, d1_wbv, d1_wbwe;
    logic [2:0] d1_fa, d1_fb;
    logic [3:0] d1_sv;
    logic [4:0] d1_wbrd;
`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] d0_pst, d0_pfl, d0_plu, d1_pst, d1_pfl, d1_plu;
`endif

    pipe_hazard_ctrl #(.REG_ADDRESS_LENGTH(5), .DEPTH(2), .LOAD_LATENCY(0), .R0_IS_ZERO(0)) u_dut0 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs_a(rs_a), .id_rs_b(rs_b),
        .id_use_a(use_a), .id_use_b(use_b), .id_rd(rd), .id_we(we), .id_is_load(ld),
        .id_is_mem(mem), .branch_taken(br), .dmem_ack(ack), .pc_stall(d0_pc),
        .ifid_stall(d0_ifs), .ifid_flush(d0_fl), .idex_bubble(d0_bub), .dmem_req(d0_req),
        .fwd_sel_a(d0_fa), .fwd_sel_b(d0_fb), .stage_valid(d0_sv),
`ifdef PIPE_HAZARD_PERF_EN
        .perf_stall_cnt(d0_pst), .perf_flush_cnt(d0_pfl), .perf_lu_cnt(d0_plu),
`endif
        .wb_valid(d0_wbv), .wb_we(d0_wbwe), .wb_rd(d0_wbrd));

    pipe_hazard_ctrl #(.REG_ADDRESS_LENGTH(5), .DEPTH(4), .LOAD_LATENCY(1), .R0_IS_ZERO(1)) u_dut1 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs_a(rs_a), .id_rs_b(rs_b),
        .id_use_a(use_a), .id_use_b(use_b), .id_rd(rd), .id_we(we), .id_is_load(ld),
        .id_is_mem(mem), .branch_taken(br), .dmem_ack(ack), .pc_stall(d1_pc),
        .ifid_stall(d1_ifs), .ifid_flush(d1_fl), .idex_bubble(d1_bub), .dmem_req(d1_req),
        .fwd_sel_a(d1_fa), .fwd_sel_b(d1_fb), .stage_valid(d1_sv),
`ifdef PIPE_HAZARD_PERF_EN
        .perf_stall_cnt(d1_pst), .perf_flush_cnt(d1_pfl), .perf_lu_cnt(d1_plu),
`endif
        .wb_valid(d1_wbv), .wb_we(d1_wbwe), .wb_rd(d1_wbrd));

    int n_vec = 0;
    int n_err = 0;

    // Reference: history of instructions that left ID, index 0 = most recent.
    typedef struct packed { logic v; logic we; logic ld; logic mem; logic [4:0] rd; } ment_t;
    ment_t       m [2][8];
    logic [31:0] mc_st [2];
    logic [31:0] mc_fl [2];
    logic [31:0] mc_lu [2];

    function automatic int dep(input int i);
        return (i == 0) ? 2 : 4;
    endfunction

    function automatic int mfwd(input int i, input logic [4:0] rs, input logic u);
        if (!u || (i == 1 && rs == 5'd0)) return 0;
        for (int k = 0; k < dep(i); k++)
            if (m[i][k].v && m[i][k].we && m[i][k].rd == rs) return k + 1;
        return 0;
    endfunction

    function automatic logic mlu(input int i);
        return (i == 1) && id_valid && m[i][0].ld &&
               (mfwd(i, rs_a, use_a) == 1 || mfwd(i, rs_b, use_b) == 1);
    endfunction

    function automatic logic [27:0] pk(input logic pc, ifs, fl, bub, req,
                                       input logic [3:0] fa, fb, input logic [7:0] sv,
                                       input logic wbv, wbwe, input logic [4:0] wbrd);
        return {pc, ifs, fl, bub, req, fa, fb, sv, wbv, wbwe, wbrd};
    endfunction

    function automatic logic [27:0] mexp(input int i);
        logic req, frz, lu, fl;
        logic [7:0] sv;
        ment_t wb;
        req = m[i][0].v && m[i][0].mem;
        frz = req && !ack;
        lu  = mlu(i);
        fl  = br && id_valid && !frz && !lu;
        sv  = '0;
        for (int k = 0; k < dep(i); k++) sv[k] = m[i][k].v;
        wb  = m[i][dep(i) - 1];
        return pk(frz || lu, frz || lu, fl, !frz && lu, req,
                  4'(mfwd(i, rs_a, use_a)), 4'(mfwd(i, rs_b, use_b)), sv,
                  wb.v, wb.v && wb.we, wb.rd);
    endfunction

    task automatic mclear();
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 8; k++) m[i][k] = '0;
            mc_st[i] = '0; mc_fl[i] = '0; mc_lu[i] = '0;
        end
    endtask

    task automatic mupdate();
        for (int i = 0; i < 2; i++) begin
            logic frz, lu, fl;
            frz = m[i][0].v && m[i][0].mem && !ack;
            lu  = mlu(i);
            fl  = br && id_valid && !frz && !lu;
            if (frz && mc_st[i] != 32'hFFFF_FFFF) mc_st[i] = mc_st[i] + 1;
            if (fl  && mc_fl[i] != 32'hFFFF_FFFF) mc_fl[i] = mc_fl[i] + 1;
            if (lu  && mc_lu[i] != 32'hFFFF_FFFF) mc_lu[i] = mc_lu[i] + 1;
            if (!frz) begin
                for (int k = 7; k > 0; k--) m[i][k] = m[i][k-1];
                m[i][0] = lu ? ment_t'('0) : ment_t'({id_valid, we, ld, mem, rd});
            end
        end
    endtask

    task automatic chk(input string name, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", name, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [27:0] e, a;
        for (int i = 0; i < 2; i++) begin
            e = mexp(i);
            if (i == 0)
                a = pk(d0_pc, d0_ifs, d0_fl, d0_bub, d0_req, 4'(d0_fa), 4'(d0_fb), 8'(d0_sv),
                       d0_wbv, d0_wbwe, d0_wbrd);
            else
                a = pk(d1_pc, d1_ifs, d1_fl, d1_bub, d1_req, 4'(d1_fa), 4'(d1_fb), 8'(d1_sv),
                       d1_wbv, d1_wbwe, d1_wbrd);
            n_vec++;
            if (a !== e) begin
                n_err++;
                $display("FAIL %s dut%0d outputs: got %h want %h", tag, i, a, e);
            end
        end
`ifdef PIPE_HAZARD_PERF_EN
        n_vec++;
        if ({d0_pst, d0_pfl, d0_plu, d1_pst, d1_pfl, d1_plu} !==
            {mc_st[0], mc_fl[0], mc_lu[0], mc_st[1], mc_fl[1], mc_lu[1]}) begin
            n_err++;
            $display("FAIL %s perf: got %0d/%0d/%0d %0d/%0d/%0d want %0d/%0d/%0d %0d/%0d/%0d", tag,
                     d0_pst, d0_pfl, d0_plu, d1_pst, d1_pfl, d1_plu,
                     mc_st[0], mc_fl[0], mc_lu[0], mc_st[1], mc_fl[1], mc_lu[1]);
        end
`endif
    endtask

    // Called just after a falling edge with inputs applied; returns at the next falling edge.
    task automatic step(input string tag);
        #2;
        if (!rst) mclear();
        check_all(tag);
        if (rst) mupdate();
        @(negedge clk);
    endtask

    task automatic drv(input logic v, input logic [4:0] ra, rb, input logic ua, ub,
                       input logic [4:0] d, input logic w, l, mm, b, a);
        id_valid = v; rs_a = ra; rs_b = rb; use_a = ua; use_b = ub;
        rd = d; we = w; ld = l; mem = mm; br = b; ack = a;
    endtask

    typedef struct packed {
        logic v; logic [4:0] ra; logic [4:0] rb; logic ua; logic ub; logic [4:0] rd;
        logic we; logic ld; logic mem; logic br; logic ack;
        logic [1:0] fa; logic [1:0] fb; logic [1:0] sv; logic pc; logic fl; logic req;
        logic [4:0] wbrd;
    } vec_t;
    vec_t tbl [12];

    initial begin
        //          v ra    rb    ua ub rd    we ld mm br ak  fa fb sv     pc fl rq wbrd
        tbl[0]  = '{1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0, 0, 1, 0, 0, 2'b00, 0, 0, 0, 5'd0};
        tbl[1]  = '{1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0, 0, 1, 0, 0, 2'b01, 0, 0, 0, 5'd0};
        tbl[2]  = '{1, 5'd3, 5'd4, 1, 1, 5'd6, 1, 0, 0, 0, 1, 1, 0, 2'b11, 0, 0, 0, 5'd3};
        tbl[3]  = '{1, 5'd4, 5'd3, 1, 1, 5'd7, 0, 0, 0, 0, 1, 0, 2, 2'b11, 0, 0, 0, 5'd3};
        tbl[4]  = '{1, 5'd7, 5'd6, 1, 1, 5'd0, 0, 0, 0, 1, 1, 0, 2, 2'b11, 0, 1, 0, 5'd6};
        tbl[5]  = '{0, 5'd0, 5'd0, 1, 1, 5'd0, 0, 0, 0, 1, 1, 0, 0, 2'b11, 0, 0, 0, 5'd7};
        tbl[6]  = '{1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, 1, 0, 0, 2'b10, 0, 0, 0, 5'd0};
        tbl[7]  = '{1, 5'd0, 5'd0, 0, 0, 5'd9, 1, 0, 0, 0, 0, 0, 0, 2'b01, 1, 0, 1, 5'd0};
        tbl[8]  = '{1, 5'd0, 5'd0, 0, 0, 5'd9, 1, 0, 0, 0, 0, 0, 0, 2'b01, 1, 0, 1, 5'd0};
        tbl[9]  = '{1, 5'd0, 5'd0, 0, 0, 5'd9, 1, 0, 0, 0, 1, 0, 0, 2'b01, 0, 0, 1, 5'd0};
        tbl[10] = '{0, 5'd9, 5'd0, 1, 0, 5'd0, 0, 0, 0, 0, 0, 1, 0, 2'b11, 0, 0, 0, 5'd0};
        tbl[11] = '{0, 5'd9, 5'd0, 1, 0, 5'd0, 0, 0, 0, 0, 0, 2, 0, 2'b10, 0, 0, 0, 5'd9};

        mclear();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        step("reset");
        rst = 1'b1;

        for (int t = 0; t < 12; t++) begin
            drv(tbl[t].v, tbl[t].ra, tbl[t].rb, tbl[t].ua, tbl[t].ub, tbl[t].rd,
                tbl[t].we, tbl[t].ld, tbl[t].mem, tbl[t].br, tbl[t].ack);
            #1;
            chk($sformatf("tbl%0d fwd_a", t), int'(d0_fa), int'(tbl[t].fa));
            chk($sformatf("tbl%0d fwd_b", t), int'(d0_fb), int'(tbl[t].fb));
            chk($sformatf("tbl%0d stage_valid", t), int'(d0_sv), int'(tbl[t].sv));
            chk($sformatf("tbl%0d pc_stall", t), int'(d0_pc), int'(tbl[t].pc));
            chk($sformatf("tbl%0d ifid_flush", t), int'(d0_fl), int'(tbl[t].fl));
            chk($sformatf("tbl%0d dmem_req", t), int'(d0_req), int'(tbl[t].req));
            chk($sformatf("tbl%0d wb_rd", t), int'(d0_wbrd), int'(tbl[t].wbrd));
            step($sformatf("tbl%0d", t));
        end

        // Mid-stream reset, then a single writer walks to writeback.
        rst = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("rst_outputs_dut0", int'(pk(d0_pc, d0_ifs, d0_fl, d0_bub, d0_req, 4'(d0_fa), 4'(d0_fb),
            8'(d0_sv), d0_wbv, d0_wbwe, d0_wbrd)), 0);
        chk("rst_stage_valid_dut1", int'(d1_sv), 0);
        step("mid_reset");
        rst = 1'b1;
        drv(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 1);
        step("add_r3");
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        #1 chk("add_r3 stage_valid", int'(d0_sv), 1);
        step("add_r3_1");
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        #1 chk("add_r3 wb_rd", int'(d0_wbrd), 3);
        chk("add_r3 wb_we", int'(d0_wbwe), 1);
        step("add_r3_2");

        // Load-use with a taken branch in ID.
        drv(1, 0, 0, 0, 0, 5, 1, 1, 1, 0, 1);
        step("load_r5");
        drv(1, 5, 0, 1, 0, 8, 1, 0, 0, 1, 1);
        #1;
        chk("lu stall dut1", int'({d1_pc, d1_ifs, d1_bub}), 7);
        chk("lu flush dut1", int'(d1_fl), 0);
        chk("ll0 fwd_a dut0", int'(d0_fa), 1);
        chk("ll0 no stall dut0", int'(d0_pc), 0);
        step("lu_stall");
        drv(1, 5, 0, 1, 0, 8, 1, 0, 0, 1, 1);
        #1;
        chk("lu release fwd_a dut1", int'(d1_fa), 2);
        chk("lu release flush dut1", int'(d1_fl), 1);
        chk("lu release pc_stall dut1", int'(d1_pc), 0);
        step("lu_release");
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        #1 chk("branch entered entry0 dut1", int'(d1_sv), 4'b0101);
        step("lu_after");

        // r0 writer: forwarded only when register 0 is not hardwired.
        drv(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
        step("write_r0");
        drv(1, 0, 0, 1, 0, 1, 1, 0, 0, 0, 1);
        #1;
        chk("r0 fwd_a dut0", int'(d0_fa), 1);
        chk("r0 fwd_a dut1", int'(d1_fa), 0);
        step("read_r0");

        // Freeze over a branch: flush only on the release cycle.
        drv(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        step("store");
        for (int c = 0; c < 3; c++) begin
            drv(1, 0, 0, 0, 0, 2, 1, 0, 0, 1, 0);
            #1;
            chk($sformatf("freeze%0d flush", c), int'({d0_fl, d1_fl}), 0);
            chk($sformatf("freeze%0d pc_stall/req", c), int'({d0_pc, d0_req, d0_bub}), 3'b110);
            step($sformatf("freeze%0d", c));
        end
        drv(1, 0, 0, 0, 0, 2, 1, 0, 0, 1, 1);
        #1;
        chk("freeze release flush", int'({d0_fl, d1_fl}), 3);
        chk("freeze release pc_stall", int'({d0_pc, d1_pc}), 0);
        step("freeze_release");

        // Randomised traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 199) != 0);
            drv($urandom_range(0, 9) < 8, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7, 5'($urandom_range(0, 3)),
                $urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0, $urandom_range(0, 9) < 3,
                $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 6);
            step("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Parametrised hazard, forwarding and stall controller for the next-generation in-order integer pipeline. It replaces the single-entry RD comparison with a shadow scoreboard of DEPTH post-decode stages. It adds load-use stalls, a data-memory request/ack handshake that freezes the pipe, and gated branch flush. It sits beside decode, drives the PC/IF-ID/ID-EX control and the operand forwarding muxes, and owns no datapath.

Parameters:
REG_ADDRESS_LENGTH, 5, register index width
DEPTH, 2, tracked stages after ID (entry 0 = EX/MEM, entry DEPTH-1 = WB), range 1..8
LOAD_LATENCY, 0, extra cycles before load data can be forwarded (0 or 1)
R0_IS_ZERO, 0, if 1, register 0 never matches for forwarding or hazards
FWD_W, $clog2(DEPTH+1), forward-select width (derived, do not override)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
id_valid  in  1  ID holds a real instruction
id_rs_a  in  REG_ADDRESS_LENGTH  source A index
id_rs_b  in  REG_ADDRESS_LENGTH  source B index
id_use_a  in  1  source A is read
id_use_b  in  1  source B is read
id_rd  in  REG_ADDRESS_LENGTH  destination index
id_we  in  1  ID instruction writes rd
id_is_load  in  1  ID instruction is a load
id_is_mem  in  1  ID instruction accesses dmem
branch_taken  in  1  branch resolved taken in ID (combinational)
dmem_ack  in  1  dmem completes the access requested this cycle
pc_stall  out  1  hold PC
ifid_stall  out  1  hold IF/ID register
ifid_flush  out  1  zero IF/ID register
idex_bubble  out  1  load NOP into ID/EX register
dmem_req  out  1  entry 0 requests dmem
fwd_sel_a  out  FWD_W  0 = register file, k = entry k-1
fwd_sel_b  out  FWD_W  same, for source B
stage_valid  out  DEPTH  per-entry valid
wb_valid  out  1  entry DEPTH-1 valid
wb_we  out  1  entry DEPTH-1 write enable (gated by valid)
wb_rd  out  REG_ADDRESS_LENGTH  entry DEPTH-1 destination

Behaviour:
- Scoreboard entry fields: valid, we, rd, is_load, is_mem.
- Reset (rst low, async): all entries cleared and state RUN. All outputs 0 combinationally through the cleared state.
- match(k,s): entry k valid & we & rd==rs_s & use_s & !(R0_IS_ZERO & rs_s==0).
- fwd_sel_s: k+1 for the smallest matching k (youngest wins), else 0. Purely combinational.
- load_use: LOAD_LATENCY==1 & id_valid & entry 0 is_load & (match(0,a)|match(0,b)). Always 0 when LOAD_LATENCY==0.
- dmem_req = entry 0 valid & is_mem.
- FSM states: RUN and MEM_WAIT.
  - RUN: if dmem_req & !dmem_ack, go to MEM_WAIT.
  - MEM_WAIT: dmem_req held (entry 0 frozen). On dmem_ack, return to RUN; the advance happens on that same edge.
- freeze = dmem_req & !dmem_ack, in either state.
  - pc_stall = ifid_stall = 1; entries hold.
  - idex_bubble = 0 (ID/EX also holds; the datapath must treat stall as hold).
- Otherwise, if load_use:
  - pc_stall = ifid_stall = 1, idex_bubble = 1.
  - Shift with a bubble into entry 0.
- Otherwise, normal advance: entry 0 <= ID fields with valid = id_valid; entry k <= entry k-1.
- ifid_flush = branch_taken & id_valid & !freeze & !load_use, asserted for one cycle per taken branch. A branch held by a stall re-asserts branch_taken once released and flushes then.
- Simultaneous flush and normal advance: the branch itself enters entry 0; only the IF/ID slot is zeroed.
- Reset asserted mid-MEM_WAIT drops the request immediately; there is no ack tracking after reset.
- Entry DEPTH-1 is dropped each advance.

Optional Feature:
PIPE_HAZARD_PERF_EN.
- When defined, adds outputs perf_stall_cnt[31:0], perf_flush_cnt[31:0] and perf_lu_cnt[31:0].
- The counters count freeze cycles, ifid_flush pulses and load_use cycles respectively.
- Counters saturate at 32'hFFFFFFFF and clear on reset.
- When undefined, these ports and counters do not exist and the behaviour is otherwise identical.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - the entry struct typedef (valid, we, rd, is_load, is_mem);
  - the FSM state enum (RUN, MEM_WAIT);
  - the FWD_SEL_REGFILE = 0 constant.
- One sub-module, fwd_prio_sel: a combinational youngest-match priority encoder over DEPTH entries, instantiated once per source.

Test Plan:
1. Reset with rst=0 mid-stream -> all outputs 0, stage_valid=0; after release, an ID add r3 (id_we=1) appears at stage_valid=2'b01 after 1 clk and wb_rd=3 after 2 clk.
2. Back-to-back r3 writers, then ID reads r3 on A (DEPTH=2) -> fwd_sel_a=1 (youngest), not 2; with R0_IS_ZERO=1 and rs_a=0 -> fwd_sel_a=0.
3. LOAD_LATENCY=1: load r5, then add using r5 -> one cycle with pc_stall=ifid_stall=idex_bubble=1, entry 0 invalid; next cycle fwd_sel=2. With LOAD_LATENCY=0 -> no stall, fwd_sel=1.
4. Store in entry 0, dmem_ack low 3 cycles -> dmem_req=1 and pc_stall=1 for 3 cycles, stage_valid frozen; advance on the ack cycle; PIPE_HAZARD_PERF_EN perf_stall_cnt=3.
5. branch_taken=1 coinciding with a freeze -> ifid_flush=0 during freeze, ifid_flush=1 for exactly the release cycle.
6. branch_taken=1 with load_use=1 -> stall cycle has ifid_flush=0; following cycle ifid_flush=1, the branch enters entry 0.
